// File: rtl/wb_fetch_unit.sv
// Purpose : instruction fetch stage; Wishbone classic read master feeding a small
//           prefetch FIFO that presents {pc, inst, fault} to decode.
// Latency : stb rises edge N, 1-cycle slave acks at N+1, entry visible at N+2
//           (one word per 3 clk).
// Backpr. : decode stalls with ready_i=0; no new read issues while the FIFO is full.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   flush_i/flush_pc_i  redirect pulse and target (low two bits ignored)
//   wb_*                Wishbone classic master (reads only, all outputs registered)
//   valid_o/pc_o/
//   inst_o/fault_o      FIFO head, driven from registers only
//   ready_i             decode accepts head (pop on valid_o & ready_i)
module wb_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        fault_o,
    input  logic        ready_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q,     addr_d;
    logic             cyc_q,      cyc_d;     // stb always mirrors cyc: one read per cycle
    logic [3:0]       sel_q,      sel_d;

    logic [31:0]      pc_mem_q    [FIFO_DEPTH];
    logic [31:0]      pc_mem_d    [FIFO_DEPTH];
    logic [31:0]      inst_mem_q  [FIFO_DEPTH];
    logic [31:0]      inst_mem_d  [FIFO_DEPTH];
    logic             fault_mem_q [FIFO_DEPTH];
    logic             fault_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic             bus_done;
    logic             push;
    logic             pop;
    logic [31:0]      push_inst;
    logic             push_fault;
    logic             head_vld;

    // Word alignment of the redirect target is forced, so its low bits are dropped.
    logic             unused_flush_lsb;
    assign unused_flush_lsb = ^flush_pc_i[1:0];

    assign head_vld = (count_q != '0);

    // ------------------------------------------------------------------
    // Fetch FSM and bus master
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        cyc_d      = cyc_q;
        push       = 1'b0;
        push_inst  = wb_dat_i;
        push_fault = 1'b0;
        bus_done   = wb_ack_i | wb_err_i;

        case (state_q)
            ST_IDLE: begin
                // Only one read is ever outstanding, so checking the current
                // count is enough to rule out overflow.
                if (count_q < DEPTH_C) begin
                    state_d = ST_REQ;
                    cyc_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (wb_err_i) begin
                    push       = 1'b1;
                    push_inst  = 32'h0;
                    push_fault = 1'b1;
                    cyc_d      = 1'b0;
                    state_d    = ST_HALT;
                end else if (wb_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    cyc_d      = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Response belongs to the pre-redirect stream; close the cycle only.
                if (bus_done) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // HALT: wait for a redirect.
            end
        endcase

        // Redirect overrides everything above except reset. An open bus cycle
        // is never abandoned: without a response it keeps running as DRAIN.
        if (flush_i) begin
            push       = 1'b0;
            fetch_pc_d = {flush_pc_i[31:2], 2'b00};
            addr_d     = addr_q;
            if ((state_q == ST_REQ) || (state_q == ST_DRAIN)) begin
                if (bus_done) begin
                    cyc_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cyc_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end else begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        end

        sel_d = cyc_d ? 4'hf : 4'h0;
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    always_comb begin
        pc_mem_d    = pc_mem_q;
        inst_mem_d  = inst_mem_q;
        fault_mem_d = fault_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop         = head_vld & ready_i & ~flush_i;

        if (push) begin
            pc_mem_d[wr_ptr_q]    = fetch_pc_q;
            inst_mem_d[wr_ptr_q]  = push_inst;
            fault_mem_d[wr_ptr_q] = push_fault;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flush empties the queue; stale entries stay in the array but are
        // unreachable and masked at the outputs.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            addr_q      <= 32'h0;
            cyc_q       <= 1'b0;
            sel_q       <= 4'h0;
            pc_mem_q    <= '{default: '0};
            inst_mem_q  <= '{default: '0};
            fault_mem_q <= '{default: 1'b0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            addr_q      <= addr_d;
            cyc_q       <= cyc_d;
            sel_q       <= sel_d;
            pc_mem_q    <= pc_mem_d;
            inst_mem_q  <= inst_mem_d;
            fault_mem_q <= fault_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = 32'h0;
    assign wb_sel_o  = sel_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = 1'b0;

    // Head fields read as zero while the FIFO is empty.
    assign valid_o = head_vld;
    assign pc_o    = head_vld ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign inst_o  = head_vld ? inst_mem_q[rd_ptr_q]  : 32'h0;
    assign fault_o = head_vld ? fault_mem_q[rd_ptr_q] : 1'b0;

endmodule
